// File: rtl/s100_bus_ctrl.sv
// S-100 bus controller: region/port decode, per-region wait states, write
// protection, status latch, CPU clock enable and turn-key boot jump.
module s100_bus_ctrl #(
  parameter int                   NREG     = 4,
  parameter logic [NREG*8-1:0]    REG_BASE = {8'h00, 8'hFB, 8'hFD, 8'h20},
  parameter logic [NREG*8-1:0]    REG_MASK = {8'hE0, 8'hFF, 8'hFF, 8'hE0},
  parameter logic [NREG-1:0]      REG_RO   = 4'b0100,
  parameter int                   WS_W     = 2,
  parameter logic [NREG*WS_W-1:0] REG_WS   = 8'b00_00_01_00,
  parameter int                   NIO      = 1,
  parameter logic [NIO*8-1:0]     IO_BASE  = 8'h00,
  parameter logic [NIO*8-1:0]     IO_MASK  = 8'hEE,
  parameter bit                   BOOT_EN  = 1'b1,
  parameter logic [15:0]          BOOT_VEC = 16'hFD00
) (
  input  logic              clk,
  input  logic              reset,
  output logic              cpu_ce,
  input  logic [15:0]       addr,
  input  logic [7:0]        odata,
  input  logic              sync,
  input  logic              rd,
  input  logic              wr_n,
  output logic [7:0]        idata,
  output logic [NREG-1:0]   mem_rd,
  output logic [NREG-1:0]   mem_we,
  input  logic [NREG*8-1:0] mem_dout,
  output logic [NIO-1:0]    io_rd,
  output logic [NIO-1:0]    io_we,
  input  logic [NIO*8-1:0]  io_dout,
  output logic [7:0]        stat,
  output logic              boot_active,
  output logic              wp_err
);

  typedef enum logic [1:0] {BOOT0, BOOT1, BOOT2, RUN} boot_t;

  boot_t             state, state_nxt;
  logic              phase;
  logic [WS_W:0]     wcnt;
  logic [WS_W:0]     ws_load;
  logic              strobe_seen;
  logic              strobe, io_cyc, booting, start;
  logic              reg_hit, reg_ro;
  logic [NREG-1:0]   reg_oh;
  logic [7:0]        reg_rdata;
  logic [WS_W-1:0]   reg_ws;
  logic [NIO-1:0]    io_oh;
  logic [7:0]        io_rdata;

  always_comb begin
    reg_hit   = 1'b0;
    reg_oh    = '0;
    reg_rdata = 8'hFF;
    reg_ws    = '0;
    reg_ro    = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (!reg_hit && ((addr[15:8] & REG_MASK[8*i +: 8]) ==
                       (REG_BASE[8*i +: 8] & REG_MASK[8*i +: 8]))) begin
        reg_hit   = 1'b1;
        reg_oh[i] = 1'b1;
        reg_rdata = mem_dout[8*i +: 8];
        reg_ws    = REG_WS[WS_W*i +: WS_W];
        reg_ro    = REG_RO[i];
      end
    end
  end

  always_comb begin
    io_oh    = '0;
    io_rdata = 8'hFF;
    for (int j = 0; j < NIO; j++) begin
      if (io_oh == '0 && ((addr[7:0] & IO_MASK[8*j +: 8]) ==
                          (IO_BASE[8*j +: 8] & IO_MASK[8*j +: 8]))) begin
        io_oh[j] = 1'b1;
        io_rdata = io_dout[8*j +: 8];
      end
    end
  end

  assign strobe      = rd | ~wr_n;
  assign io_cyc      = stat[6] | stat[4];
  assign booting     = (state != RUN);
  assign boot_active = booting;
  assign cpu_ce      = phase & (wcnt == '0);
  assign start       = strobe & cpu_ce & ~strobe_seen;

  assign mem_rd = (rd & ~io_cyc & ~booting) ? reg_oh : '0;
  assign mem_we = (~wr_n & ~io_cyc & ~reg_ro) ? reg_oh : '0;
  assign io_rd  = (rd & io_cyc) ? io_oh : '0;
  assign io_we  = (~wr_n & io_cyc) ? io_oh : '0;

  // wcnt counts clocks; one wait state is one full CPU step, i.e. two clocks.
  assign ws_load = (io_cyc || (booting && rd)) ? {(WS_W+1){1'b0}} : {reg_ws, 1'b0};

  always_comb begin
    idata = reg_rdata;
    if (io_cyc) begin
      idata = io_rdata;
    end else if (booting) begin
      case (state)
        BOOT0:   idata = 8'hC3;
        BOOT1:   idata = BOOT_VEC[7:0];
        default: idata = BOOT_VEC[15:8];
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    if (rd && cpu_ce) begin
      case (state)
        BOOT0:   state_nxt = BOOT1;
        BOOT1:   state_nxt = BOOT2;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT_EN ? BOOT0 : RUN;
      phase       <= 1'b0;
      wcnt        <= '0;
      strobe_seen <= 1'b0;
      stat        <= 8'h00;
      wp_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (sync)
        stat <= odata;
      if (wcnt != '0) begin
        wcnt <= wcnt - 1'b1;
      end else begin
        phase <= ~phase;
        if (start)
          wcnt <= ws_load;
      end
      strobe_seen <= strobe & (strobe_seen | cpu_ce);
      if (~wr_n && cpu_ce && !io_cyc && reg_hit && reg_ro)
        wp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_s100_bus_ctrl.sv
// Randomised scoreboard bench for s100_bus_ctrl with a transaction-level
// reference model of decode, boot jump, write protect and stall length.
module tb_s100_bus_ctrl;

  localparam int                   NREG     = 4;
  localparam logic [NREG*8-1:0]    REG_BASE = {8'h00, 8'hFB, 8'hFD, 8'h20};
  localparam logic [NREG*8-1:0]    REG_MASK = {8'hE0, 8'hFF, 8'hFF, 8'hE0};
  localparam logic [NREG-1:0]      REG_RO   = 4'b0100;
  localparam int                   WS_W     = 2;
  localparam logic [NREG*WS_W-1:0] REG_WS   = 8'b00_00_01_00;
  localparam int                   NIO      = 1;
  localparam logic [NIO*8-1:0]     IO_BASE  = 8'h00;
  localparam logic [NIO*8-1:0]     IO_MASK  = 8'hEE;
  localparam logic [15:0]          BOOT_VEC = 16'hFD00;
  localparam int                   BOUND    = 50;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cpu_ce;
  logic [15:0]       addr = '0;
  logic [7:0]        odata = '0;
  logic              sync = 1'b0;
  logic              rd = 1'b0;
  logic              wr_n = 1'b1;
  logic [7:0]        idata;
  logic [NREG-1:0]   mem_rd, mem_we;
  logic [NREG*8-1:0] mem_dout = '0;
  logic [NIO-1:0]    io_rd, io_we;
  logic [NIO*8-1:0]  io_dout = '0;
  logic [7:0]        stat;
  logic              boot_active, wp_err;

  s100_bus_ctrl #(
    .NREG(NREG), .REG_BASE(REG_BASE), .REG_MASK(REG_MASK), .REG_RO(REG_RO),
    .WS_W(WS_W), .REG_WS(REG_WS), .NIO(NIO), .IO_BASE(IO_BASE),
    .IO_MASK(IO_MASK), .BOOT_EN(1'b1), .BOOT_VEC(BOOT_VEC)
  ) dut (
    .clk(clk), .reset(reset), .cpu_ce(cpu_ce), .addr(addr), .odata(odata),
    .sync(sync), .rd(rd), .wr_n(wr_n), .idata(idata), .mem_rd(mem_rd),
    .mem_we(mem_we), .mem_dout(mem_dout), .io_rd(io_rd), .io_we(io_we),
    .io_dout(io_dout), .stat(stat), .boot_active(boot_active), .wp_err(wp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              is_rd;
    logic [7:0]      data;
    logic [NREG-1:0] mrd, mwe;
    logic [NIO-1:0]  ird, iwe;
  } exp_t;

  exp_t       sbq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] m_stat = 8'h00;
  int         boot_idx = 0;
  bit         m_wp = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  function automatic int reg_hit_idx(input logic [15:0] a);
    for (int i = 0; i < NREG; i++)
      if ((a[15:8] & REG_MASK[8*i +: 8]) == (REG_BASE[8*i +: 8] & REG_MASK[8*i +: 8]))
        return i;
    return -1;
  endfunction

  function automatic int io_hit_idx(input logic [7:0] p);
    for (int i = 0; i < NIO; i++)
      if ((p & IO_MASK[8*i +: 8]) == (IO_BASE[8*i +: 8] & IO_MASK[8*i +: 8]))
        return i;
    return -1;
  endfunction

  function automatic logic [7:0] boot_byte(input int k);
    case (k)
      0:       return 8'hC3;
      1:       return BOOT_VEC[7:0];
      default: return BOOT_VEC[15:8];
    endcase
  endfunction

  task automatic model_reset();
    m_stat   = 8'h00;
    boot_idx = 0;
    m_wp     = 1'b0;
  endtask

  task automatic set_status(input logic [7:0] s);
    odata = s;
    sync  = 1'b1;
    @(posedge clk); #1;
    sync   = 1'b0;
    m_stat = s;
    check("stat", 32'(stat), 32'(s));
  endtask

  task automatic bus_cycle(input bit is_rd, input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    int   ri, ii, ws, n, gap;
    bit   io, done, wp_hit;
    for (int i = 0; i < NREG; i++) mem_dout[8*i +: 8] = 8'($urandom);
    for (int i = 0; i < NIO; i++)  io_dout[8*i +: 8]  = 8'($urandom);
    io = m_stat[6] | m_stat[4];
    ri = reg_hit_idx(a);
    ii = io_hit_idx(a[7:0]);
    e.is_rd = is_rd;
    e.data  = 8'hFF;
    e.mrd = '0; e.mwe = '0; e.ird = '0; e.iwe = '0;
    ws = 0;
    wp_hit = 1'b0;
    if (io) begin
      if (ii >= 0) begin
        e.data = io_dout[8*ii +: 8];
        if (is_rd) e.ird[ii] = 1'b1; else e.iwe[ii] = 1'b1;
      end
    end else if (is_rd && boot_idx < 3) begin
      e.data = boot_byte(boot_idx);
    end else if (ri >= 0) begin
      ws     = int'(REG_WS[WS_W*ri +: WS_W]);
      e.data = mem_dout[8*ri +: 8];
      if (is_rd) e.mrd[ri] = 1'b1;
      else if (!REG_RO[ri]) e.mwe[ri] = 1'b1;
      else wp_hit = 1'b1;
    end
    sbq.push_back(e);
    addr = a;
    if (is_rd) rd = 1'b1;
    else begin odata = d; wr_n = 1'b0; end
    n = 0;
    done = 1'b0;
    while (!done && n < BOUND) begin
      @(negedge clk);
      done = cpu_ce;
      @(posedge clk); #1;
      n++;
    end
    rd   = 1'b0;
    wr_n = 1'b1;
    if (!done) begin
      check("cycle_timeout", 32'(n), 32'(BOUND + 1));
      sbq.delete();
    end
    if (wp_hit) m_wp = 1'b1;
    if (is_rd && boot_idx < 3) boot_idx++;
    check("boot_active", 32'(boot_active), 32'(boot_idx < 3));
    check("wp_err", 32'(wp_err), 32'(m_wp));
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!cpu_ce && gap < BOUND);
    check("ce_gap", 32'(gap), 32'(2 + 2 * ws));
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && cpu_ce && (rd || !wr_n)) begin
        if (sbq.size() == 0) begin
          check("unexpected_cycle", 32'(addr), 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          if (e.is_rd) check("idata", 32'(idata), 32'(e.data));
          check("mem_rd", 32'(mem_rd), 32'(e.mrd));
          check("mem_we", 32'(mem_we), 32'(e.mwe));
          check("io_rd", 32'(io_rd), 32'(e.ird));
          check("io_we", 32'(io_we), 32'(e.iwe));
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_cpu_ce"}, 32'(cpu_ce), 32'd0);
    check({tag, "_stat"}, 32'(stat), 32'd0);
    check({tag, "_boot_active"}, 32'(boot_active), 32'd1);
    check({tag, "_wp_err"}, 32'(wp_err), 32'd0);
    check({tag, "_enables"}, 32'({mem_rd, mem_we, io_rd, io_we}), 32'd0);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return {8'hFD, 8'($urandom)};
      1:       return {8'hFB, 8'($urandom)};
      2:       return 16'($urandom_range(0, 16'h3FFF));
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] rand_port();
    case ($urandom_range(0, 4))
      0:       return 8'h00;
      1:       return 8'h01;
      2:       return 8'h10;
      3:       return 8'h11;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    reset = 1'b1;
    @(posedge clk); #1;

    // Boot jump: three reads at arbitrary addresses return the JMP instruction.
    set_status(8'hA2);
    for (int k = 0; k < 3; k++) bus_cycle(1'b1, 16'($urandom), 8'h00);
    bus_cycle(1'b1, 16'hFD00, 8'h00);
    bus_cycle(1'b1, 16'hFD10, 8'h00);
    bus_cycle(1'b1, 16'h0100, 8'h00);
    bus_cycle(1'b1, 16'h8000, 8'h00);
    set_status(8'h00);
    bus_cycle(1'b0, 16'hFB00, 8'h55);
    bus_cycle(1'b0, 16'hFD00, 8'h55);
    set_status(8'h10);
    bus_cycle(1'b0, 16'h0011, 8'hA5);
    set_status(8'h42);
    bus_cycle(1'b1, 16'h0002, 8'h00);
    bus_cycle(1'b1, 16'h0010, 8'h00);

    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 3))
        0: begin set_status(8'($urandom) & 8'hAF); bus_cycle(1'b1, rand_addr(), 8'h00); end
        1: begin set_status(8'($urandom) & 8'hAF); bus_cycle(1'b0, rand_addr(), 8'($urandom)); end
        2: begin set_status((8'($urandom) & 8'hEF) | 8'h40);
                 bus_cycle(1'b1, {8'($urandom), rand_port()}, 8'h00); end
        default: begin set_status((8'($urandom) & 8'hAF) | 8'h10);
                 bus_cycle(1'b0, {8'($urandom), rand_port()}, 8'($urandom)); end
      endcase
    end

    // Reset during the second boot read, then the sequence restarts.
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    bus_cycle(1'b1, 16'h1234, 8'h00);
    addr = 16'h4321;
    rd   = 1'b1;
    #2 reset = 1'b0;
    #1;
    check_reset_state("midrst");
    rd = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) bus_cycle(1'b1, 16'($urandom), 8'h00);
    bus_cycle(1'b1, 16'hFD00, 8'h00);

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
